bitmap_readout: RTL and testbench

Sequential reader for the 256x256, 3-bit-per-pixel dot-trace bitmap RAM. On a start pulse it walks every address of the bitmap and streams each pixel out over a valid/ready interface tagged with its (x, y) coordinate. Typical sinks are a UART dumper or a snapshot buffer. It shares the RAM port with the display/trace logic through a req/gnt handshake. Optionally it clears each pixel to 0 after reading it, giving a read-and-erase frame grab.

---
 rtl/bitmap_readout.sv | 168 ++++++++++++++++
 tb/tb_bitmap_readout.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitmap_readout.sv
// Full-frame bitmap reader; BITMAP_READOUT_CLEAR_EN adds read-and-erase (pixel cleared after each read).
// start -> first m_valid is 3 cycles; a 2-credit output FIFO throttles RAM reads under m_ready backpressure.
module bitmap_readout #(
  parameter int X_W    = 8,
  parameter int Y_W    = 8,
  parameter int DATA_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_req,
  input  logic                  mem_gnt,
  output logic [X_W+Y_W-1:0]    mem_addr,
  output logic                  mem_we,
  output logic [DATA_W-1:0]     mem_din,
  input  logic [DATA_W-1:0]     mem_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_W-1:0]     m_data,
  output logic [X_W-1:0]        m_x,
  output logic [Y_W-1:0]        m_y,
  output logic                  m_last
);

  localparam int AW = X_W + Y_W;

  typedef struct packed {
    logic [AW-1:0]     tag;
    logic [DATA_W-1:0] dat;
  } beat_t;

`ifdef BITMAP_READOUT_CLEAR_EN
  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, CLEAR = 2'd2, DRAIN = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd3} state_t;
`endif

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            done_q, done_d;
  logic            lastp_q, lastp_d;
  logic            infl_vld_q;
  logic [AW-1:0]   infl_tag_q;
  beat_t           e0_q, e0_d, e1_q, e1_d;
  logic [1:0]      cnt_q, cnt_d;

  logic            pop, last_pop, addr_last;
  logic [2:0]      used;
  logic            rd_req, wr_req, rd_gnt;
  beat_t           new_beat;

  assign pop       = m_valid & m_ready;
  assign last_pop  = pop & m_last;
  assign addr_last = &addr_q;

  // The beat leaving this cycle frees its slot immediately, so a full-rate stream keeps reading every cycle.
  assign used   = {1'b0, cnt_q} + {2'b0, infl_vld_q} - {2'b0, pop};
  assign rd_req = (state_q == READ) && (used < 3'd2);
  assign rd_gnt = rd_req & mem_gnt;

`ifdef BITMAP_READOUT_CLEAR_EN
  logic wr_gnt;
  assign wr_req = (state_q == CLEAR);
  assign wr_gnt = wr_req & mem_gnt;
`else
  assign wr_req = 1'b0;
`endif

  assign mem_req  = rd_req | wr_req;
  assign mem_we   = wr_req;
  assign mem_din  = '0;
  assign mem_addr = addr_q;

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign m_valid = (cnt_q != 2'd0);
  assign m_data  = e0_q.dat;
  assign m_x     = e0_q.tag[AW-1:Y_W];
  assign m_y     = e0_q.tag[Y_W-1:0];
  assign m_last  = m_valid & (&e0_q.tag);

  assign new_beat = '{tag: infl_tag_q, dat: mem_dout};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
    lastp_d = lastp_q | last_pop;
    case (state_q)
      IDLE: begin
        lastp_d = 1'b0;
        if (start) begin
          addr_d  = '0;
          state_d = READ;
        end
      end
      READ: begin
        if (rd_gnt) begin
`ifdef BITMAP_READOUT_CLEAR_EN
          state_d = CLEAR;
`else
          if (addr_last) state_d = DRAIN;
          else           addr_d  = addr_q + 1'b1;
`endif
        end
      end
`ifdef BITMAP_READOUT_CLEAR_EN
      CLEAR: begin
        if (wr_gnt) begin
          if (addr_last) begin
            state_d = DRAIN;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = READ;
          end
        end
      end
`endif
      // The last beat may already have left while a final clear write waited for grant.
      DRAIN: begin
        if (last_pop | lastp_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
          lastp_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q + {1'b0, infl_vld_q} - {1'b0, pop};
    if (pop) e0_d = e1_q;
    if (infl_vld_q) begin
      if (cnt_q == {1'b0, pop}) e0_d = new_beat;
      else                      e1_d = new_beat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      done_q     <= 1'b0;
      lastp_q    <= 1'b0;
      infl_vld_q <= 1'b0;
      infl_tag_q <= '0;
      e0_q       <= '0;
      e1_q       <= '0;
      cnt_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      done_q     <= done_d;
      lastp_q    <= lastp_d;
      infl_vld_q <= rd_gnt;
      infl_tag_q <= addr_q;
      e0_q       <= e0_d;
      e1_q       <= e1_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bitmap_readout.sv
// Directed bench for bitmap_readout on a 16x16 bitmap; clear-mode frames built when BITMAP_READOUT_CLEAR_EN is defined.
module tb_bitmap_readout;

`ifdef BITMAP_READOUT_CLEAR_EN
  localparam bit CLR = 1'b1;
  localparam int FULL_LEN = 514;
`else
  localparam bit CLR = 1'b0;
  localparam int FULL_LEN = 259;
`endif
  localparam int NPIX = 256;

  logic       clk, reset, start;
  logic       busy, done, mem_req, mem_gnt, mem_we;
  logic [7:0] mem_addr;
  logic [2:0] mem_din, mem_dout;
  logic       m_valid, m_ready, m_last;
  logic [2:0] m_data;
  logic [3:0] m_x, m_y;

  bitmap_readout #(.X_W(4), .Y_W(4), .DATA_W(3)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_din(mem_din), .mem_dout(mem_dout), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_x(m_x), .m_y(m_y), .m_last(m_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: synchronous read, data presented the cycle after the granted read.
  logic [2:0] ram [NPIX];
  logic [2:0] snap [NPIX];
  logic [2:0] dout_q = '0;
  int         pl_mode = 0;
  assign mem_dout = dout_q;

  always @(posedge clk) begin
    if (pl_mode == 1) begin
      for (int i = 0; i < NPIX; i++) ram[i] <= 3'(((i >> 4) ^ i) & 7);
    end else if (pl_mode == 2) begin
      for (int i = 0; i < NPIX; i++) ram[i] <= 3'd5;
    end else if (mem_req && mem_gnt) begin
      if (mem_we) ram[mem_addr] <= mem_din;
      else        dout_q <= ram[mem_addr];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Stream monitor, sampled on the falling edge.
  bit        mon_en = 0;
  int        exp_idx, beats, outst;
  int        ord_err, dat_err, last_err, stab_err, cred_err, alt_err, hold_err;
  int        done_cnt, first_v, last_cyc, done_cyc, hold_n;
  bit        stall_p, last_we, hold_chk = 0, hold_f, hold_r;
  logic [11:0] stall_v;
  logic [7:0]  hold_a, last_addr;
  bit        hs, gr;

  always @(negedge clk) begin
    if (mon_en) begin
      hs = m_valid & m_ready;
      gr = mem_req & mem_gnt & ~mem_we;
      if (stall_p && (!m_valid || {m_data, m_x, m_y, m_last} != stall_v)) stab_err++;
      stall_p = m_valid & ~m_ready;
      stall_v = {m_data, m_x, m_y, m_last};
      if (mem_req && !mem_we && (outst - int'(hs) >= 2)) cred_err++;
      outst = outst + int'(gr) - int'(hs);
      if (m_valid && first_v < 0) first_v = cyc;
      if (hs) begin
        if (exp_idx >= NPIX) ord_err++;
        else begin
          if ({m_x, m_y} != exp_idx[7:0]) ord_err++;
          if (m_data != snap[exp_idx]) dat_err++;
          if (m_last != (exp_idx == NPIX - 1)) last_err++;
        end
        if (m_last) last_cyc = cyc;
        exp_idx++;
        beats++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (mem_req && mem_gnt) begin
        if (mem_we) begin
          if (!CLR || last_we || mem_addr != last_addr || mem_din != 3'd0) alt_err++;
        end else if (CLR && !last_we) alt_err++;
        last_we   = mem_we;
        last_addr = mem_addr;
      end
      if (hold_chk) begin
        hold_n++;
        if (!hold_f) begin
          hold_f = 1;
          hold_a = mem_addr;
          hold_r = mem_req;
        end else if (mem_addr != hold_a || mem_req != hold_r) hold_err++;
      end
    end
  end

  task automatic mon_init();
    exp_idx = 0; beats = 0; outst = 0;
    ord_err = 0; dat_err = 0; last_err = 0; stab_err = 0; cred_err = 0; alt_err = 0; hold_err = 0;
    done_cnt = 0; first_v = -1; last_cyc = -1; done_cyc = -1; hold_n = 0;
    stall_p = 0; last_we = 1; hold_f = 0; hold_r = 0;
  endtask

  task automatic preload(input int mode);
    if (mode != 0) begin
      pl_mode = mode;
      @(posedge clk); #1;
      pl_mode = 0;
    end
    for (int i = 0; i < NPIX; i++) snap[i] = ram[i];
  endtask

  task automatic check_reset_outs(input string nm);
    chk({nm, "_ctl"}, {busy, done, mem_req, mem_we, m_valid, m_last}, 0);
    chk({nm, "_addr"}, mem_addr, 0);
    chk({nm, "_din"}, mem_din, 0);
    chk({nm, "_beat"}, {m_data, m_x, m_y}, 0);
  endtask

  task automatic frame(input string nm, input int pl, input int rdy_pct,
                       input int gap_at, input int start_at, input int exp_len);
    int t, n;
    bit gapped, restarted;
    gapped = 0; restarted = 0; n = 0;
    preload(pl);
    mon_init();
    mon_en = 1;
    @(posedge clk); #1;
    start = 1; t = cyc;
    @(posedge clk); #1;
    start = 0;
    chk({nm, "_busy_t1"}, busy, 1);
    chk({nm, "_req_t1"}, mem_req, 1);
    while (done_cyc < 0 && n < 4000) begin
      m_ready = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(99) < rdy_pct);
      if (gap_at >= 0 && !gapped && beats >= gap_at) begin
        gapped = 1; mem_gnt = 0; hold_chk = 1;
        repeat (10) begin @(posedge clk); #1; end
        hold_chk = 0; mem_gnt = 1;
        chk({nm, "_gap_cycles"}, hold_n, 10);
        chk({nm, "_gap_req"}, hold_r, 1);
        chk({nm, "_gap_hold"}, hold_err, 0);
      end
      if (start_at >= 0 && !restarted && beats >= start_at) begin
        restarted = 1; start = 1;
        @(posedge clk); #1;
        start = 0;
      end
      @(posedge clk); #1;
      n++;
    end
    m_ready = 1;
    chk({nm, "_done_seen"}, done_cyc >= 0, 1);
    chk({nm, "_beats"}, beats, NPIX);
    chk({nm, "_order"}, ord_err, 0);
    chk({nm, "_data"}, dat_err, 0);
    chk({nm, "_last"}, last_err, 0);
    chk({nm, "_stable"}, stab_err, 0);
    chk({nm, "_credit"}, cred_err, 0);
    chk({nm, "_memops"}, alt_err, 0);
    chk({nm, "_done_lat"}, done_cyc - last_cyc, 1);
    if (exp_len > 0) begin
      chk({nm, "_first_valid"}, first_v - t, 3);
      chk({nm, "_len"}, done_cyc - t, exp_len);
    end
    repeat (3) begin @(posedge clk); #1; end
    chk({nm, "_done_once"}, done_cnt, 1);
    chk({nm, "_idle"}, {busy, mem_req}, 0);
    mon_en = 0;
  endtask

  task automatic mid_reset();
    int n;
    n = 0;
    preload(1);
    mon_init();
    mon_en = 1;
    @(posedge clk); #1;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    while (beats < 100 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("midrst_reached", beats >= 100, 1);
    mon_en = 0;
    reset = 1;
    @(posedge clk); #1;
    check_reset_outs("midrst");
    reset = 0;
`ifdef BITMAP_READOUT_CLEAR_EN
    chk("midrst_cleared", ram[0], 0);
    chk("midrst_kept", ram[200], 4);
`endif
    @(posedge clk); #1;
    chk("midrst_idle", busy, 0);
  endtask

  initial begin
    int nz;
    reset = 1; start = 0; m_ready = 1; mem_gnt = 1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outs("rst");
    reset = 0;
    @(posedge clk); #1;

    reset = 1; start = 1;
    @(posedge clk); #1;
    reset = 0; start = 0;
    chk("rst_beats_start", busy, 0);
    @(posedge clk); #1;
    chk("rst_beats_start_req", {busy, mem_req}, 0);

    frame("full", 1, 100, -1, -1, FULL_LEN);
    frame("bp", 1, 30, -1, -1, 0);
    frame("gap", 1, 100, 60, 120, 0);
    mid_reset();
    frame("post_rst", 1, 100, -1, -1, FULL_LEN);

`ifdef BITMAP_READOUT_CLEAR_EN
    frame("clr5", 2, 100, -1, -1, FULL_LEN);
    frame("clr0", 0, 100, -1, -1, FULL_LEN);
    nz = 0;
    for (int i = 0; i < NPIX; i++) if (snap[i] != 3'd0) nz++;
    chk("clr_second_all_zero", nz, 0);
    nz = 0;
    for (int i = 0; i < NPIX; i++) if (ram[i] != 3'd0) nz++;
    chk("clr_ram_zero", nz, 0);
`else
    nz = 0;
    for (int i = 0; i < NPIX; i++) if (ram[i] != 3'(((i >> 4) ^ i) & 7)) nz++;
    chk("ro_ram_untouched", nz, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
